// File: rtl/sram_arbiter_pkg.sv
// sram_arb_pkg: shared widths, FSM state and client-select types for the SRAM arbiter
package sram_arb_pkg;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_TURN} state_t;
  typedef enum logic {CLI_VGA, CLI_BG} cli_t;
endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arb_if: VGA read client and BG read/write client request/grant/read-data bundle; master = clients, slave = arbiter
interface sram_arb_if import sram_arb_pkg::*; ();
  logic              i_vga_req;
  logic [ADDR_W-1:0] i_vga_addr;
  logic              o_vga_gnt;
  logic [DATA_W-1:0] o_vga_rdata;
  logic              o_vga_rvalid;
  logic              i_bg_req;
  logic              i_bg_we;
  logic [ADDR_W-1:0] i_bg_addr;
  logic [DATA_W-1:0] i_bg_wdata;
  logic              o_bg_gnt;
  logic [DATA_W-1:0] o_bg_rdata;
  logic              o_bg_rvalid;
  modport master (
    output i_vga_req, i_vga_addr, i_bg_req, i_bg_we, i_bg_addr, i_bg_wdata,
    input  o_vga_gnt, o_vga_rdata, o_vga_rvalid, o_bg_gnt, o_bg_rdata, o_bg_rvalid
  );
  modport slave (
    input  i_vga_req, i_vga_addr, i_bg_req, i_bg_we, i_bg_addr, i_bg_wdata,
    output o_vga_gnt, o_vga_rdata, o_vga_rvalid, o_bg_gnt, o_bg_rdata, o_bg_rvalid
  );
endinterface

// File: rtl/sram_arbiter_io_reg.sv
// sram_io_reg: registered SRAM pins (addr, active-low controls, write data, dq tristate) and tagged read-data capture; in: issue/we/tag/addr/wdata, out: SRAM pins, rdata, per-client rvalid
module sram_io_reg import sram_arb_pkg::*; (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_issue,
  input  logic              i_we,
  input  cli_t              i_tag,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [ADDR_W-1:0] o_addr,
  inout  wire  [DATA_W-1:0] io_dq,
  output logic              o_we_n,
  output logic              o_oe_n,
  output logic              o_ce_n,
  output logic              o_lb_n,
  output logic              o_ub_n,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_vga_rvalid,
  output logic              o_bg_rvalid
);
  logic [DATA_W-1:0] wdata_q;
  cli_t              tag_q, rtag_q;
  logic              rv_q;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      o_addr  <= '0;
      o_we_n  <= 1'b1;
      o_oe_n  <= 1'b1;
      o_ce_n  <= 1'b1;
      wdata_q <= '0;
      tag_q   <= CLI_VGA;
      rtag_q  <= CLI_VGA;
      rv_q    <= 1'b0;
      o_rdata <= '0;
    end else begin
      if (i_issue) o_addr <= i_addr;
      if (i_we) wdata_q <= i_wdata;
      o_ce_n <= !i_issue;
      o_we_n <= !i_we;
      o_oe_n <= !(i_issue && !i_we);
      tag_q  <= i_tag;
      rv_q   <= !o_oe_n;
      rtag_q <= tag_q;
      if (!o_oe_n) o_rdata <= io_dq;
    end
  // Whole-word accesses only: both byte lanes follow chip enable.
  assign o_lb_n = o_ce_n;
  assign o_ub_n = o_ce_n;
  assign io_dq = !o_we_n ? wdata_q : 'z;
  assign o_vga_rvalid = rv_q && rtag_q == CLI_VGA;
  assign o_bg_rvalid = rv_q && rtag_q == CLI_BG;
endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: VGA-first SRAM arbiter with BG starvation bound and write->read turnaround; ports: i_clk, i_rst, bus (client bundle), SRAM pins
module sram_arbiter import sram_arb_pkg::*; #(
  parameter int STARVE_MAX = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  sram_arb_if.slave         bus,
  output logic [ADDR_W-1:0] o_sram_addr,
  inout  wire  [DATA_W-1:0] io_sram_dq,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_ce_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  state_t            state, state_nx;
  logic [CW-1:0]     starve_cnt;
  logic              bg_win, win_rd, blocked;
  logic [DATA_W-1:0] rdata;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state      <= S_IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nx;
      starve_cnt <= (!bus.i_bg_req || bus.o_bg_gnt) ? '0 :
                    (bus.o_vga_gnt && starve_cnt != CW'(STARVE_MAX)) ? starve_cnt + 1'b1 : starve_cnt;
    end
  always_comb begin
    bg_win = bus.i_bg_req && (!bus.i_vga_req || starve_cnt == CW'(STARVE_MAX));
    win_rd = bg_win ? !bus.i_bg_we : bus.i_vga_req;
    // A read right after a write would collide with the driven dq bus; hold it one cycle.
    blocked = state == S_WR && win_rd;
    bus.o_vga_gnt = bus.i_vga_req && !bg_win && !blocked;
    bus.o_bg_gnt = bg_win && !blocked;
  end
  always_comb
    state_nx = blocked ? S_TURN :
               (bus.o_bg_gnt && bus.i_bg_we) ? S_WR :
               (bus.o_vga_gnt || bus.o_bg_gnt) ? S_RD : S_IDLE;
  sram_io_reg u_io (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_issue      (bus.o_vga_gnt || bus.o_bg_gnt),
    .i_we         (bus.o_bg_gnt && bus.i_bg_we),
    .i_tag        (bus.o_bg_gnt ? CLI_BG : CLI_VGA),
    .i_addr       (bus.o_bg_gnt ? bus.i_bg_addr : bus.i_vga_addr),
    .i_wdata      (bus.i_bg_wdata),
    .o_addr       (o_sram_addr),
    .io_dq        (io_sram_dq),
    .o_we_n       (o_sram_we_n),
    .o_oe_n       (o_sram_oe_n),
    .o_ce_n       (o_sram_ce_n),
    .o_lb_n       (o_sram_lb_n),
    .o_ub_n       (o_sram_ub_n),
    .o_rdata      (rdata),
    .o_vga_rvalid (bus.o_vga_rvalid),
    .o_bg_rvalid  (bus.o_bg_rvalid)
  );
  assign bus.o_vga_rdata = rdata;
  assign bus.o_bg_rdata = rdata;
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single 1M×16 external SRAM between the VGA frame-fetch read port and the background-subtraction statistics engine, which issues both reads and writes. Sits between those two clients and the SRAM pins. Grants at most one access per cycle and registers all SRAM pin outputs. Arbitration is VGA-first with a starvation bound for the background client. Write→read bus turnaround is handled internally.

## Interface
- ADDR_W, 20, SRAM word address width
- DATA_W, 16, SRAM data width
- STARVE_MAX, 4, consecutive lost arbitrations after which the BG client wins once

Ports:
- i_clk  in  1  system clock (100 MHz)
- i_rst  in  1  reset; one clock; reset is asynchronous and active-high
- i_vga_req  in  1  VGA read request; held with address until granted
- i_vga_addr  in  ADDR_W  VGA read address
- o_vga_gnt  out  1  VGA request accepted this cycle
- o_vga_rdata  out  DATA_W  VGA read data
- o_vga_rvalid  out  1  o_vga_rdata valid (1-cycle pulse)
- i_bg_req  in  1  BG request; held with i_bg_we, addr and wdata until granted
- i_bg_we  in  1  1 = write, 0 = read
- i_bg_addr  in  ADDR_W  BG address
- i_bg_wdata  in  DATA_W  BG write data
- o_bg_gnt  out  1  BG request accepted this cycle
- o_bg_rdata  out  DATA_W  BG read data
- o_bg_rvalid  out  1  o_bg_rdata valid (1-cycle pulse)
- o_sram_addr  out  ADDR_W  registered SRAM address
- io_sram_dq  inout  DATA_W  SRAM data; driven only during write cycles, else high-Z
- o_sram_we_n, o_sram_oe_n, o_sram_ce_n, o_sram_lb_n, o_sram_ub_n  out  1 each  active-low SRAM controls

## Operation
- FSM states:
  - S_IDLE: no access issued last cycle.
  - S_RD: read issued last cycle.
  - S_WR: write issued last cycle.
  - S_TURN: forced idle after a write.
- Arbitration runs every cycle in which at least one request is high.
  - Winner is VGA, unless starve_cnt == STARVE_MAX and i_bg_req is high; then BG wins.
  - Only the winner's gnt rises.
- starve_cnt counts cycles with i_bg_req=1, o_bg_gnt=0 and o_vga_gnt=1. It saturates at STARVE_MAX, clears on o_bg_gnt, and clears when i_bg_req=0.
- Turnaround: when the state is S_WR and the winner is a read, no gnt is issued that cycle and the FSM enters S_TURN. The read is granted in the following cycle. Write→write and read→write need no gap.
- Transitions (grant in cycle N sets the state for cycle N+1):
  - read grant → S_RD
  - write grant → S_WR
  - no request → S_IDLE
  - blocked read in S_WR → S_TURN
  - S_TURN always grants if a request is pending, else goes to S_IDLE
- Byte lanes: lb_n and ub_n are always 0 when ce_n=0; the block performs no partial writes.
- No address or data arithmetic; addresses pass through unchanged. Reads carry no ID; the source is tracked by a 1-bit registered tag.

## Timing
- Grant cycle N (o_*_gnt combinational from requests and state):
  - edge N→N+1: o_sram_addr, ce_n=0, and either we_n=0 / oe_n=1 (write) or we_n=1 / oe_n=0 (read) are registered.
  - Write: io_sram_dq is driven with the registered wdata during N+1 only.
  - Read: io_sram_dq is sampled at edge N+1→N+2; the owning rvalid is high in N+2 with its rdata.
- Read latency is 2 cycles from gnt to rvalid. Throughput is 1 access/cycle except the single S_TURN bubble.
- Idle cycle outputs: ce_n=1, we_n=1, oe_n=1, dq high-Z.
- Reset values:
  - state S_IDLE, starve_cnt 0
  - o_sram_addr 0, all SRAM controls 1, dq high-Z
  - both gnt 0, both rvalid 0, both rdata 0
- Reset mid-operation: an in-flight write is abandoned (we_n returns to 1 asynchronously) and a pending rvalid is dropped. The first grant after reset release may occur in the first clock with a request.
- Simultaneous requests from both clients: the arbitration rule above applies and the loser holds its request.

## Structure
- Package sram_arb_pkg:
  - state enum (S_IDLE, S_RD, S_WR, S_TURN)
  - typedef for client select (CLI_VGA, CLI_BG)
  - default ADDR_W/DATA_W constants
- Sub-module sram_io_reg: output registers for addr/controls/wdata, the dq tristate, and the read-data capture register. The arbiter FSM and starve counter stay in the top.

## Test plan
- Reset: assert i_rst mid-write with we_n=0 → we_n=1, ce_n=1 and dq high-Z immediately; all rvalid 0; state returns to S_IDLE.
- VGA streaming: i_vga_req held high with addresses 0,1,2,3 → gnt every cycle; SRAM model data 0xA000+addr appears on o_vga_rdata with rvalid exactly 2 cycles after each gnt.
- Contention and starvation: both requests held high (BG read) → VGA granted 4 consecutive cycles, BG granted on cycle 5, starve_cnt back to 0, then VGA again.
- Turnaround: BG write to 0x00010 (data 0x1234), then VGA read of 0x00010 requested next cycle → one cycle without gnt (S_TURN, dq high-Z, ce_n=1), then read granted; o_vga_rdata=0x1234.
- BG read-modify-write: BG read 0x00020, then BG write 0x00021 back-to-back → no bubble; o_bg_rvalid only (never o_vga_rvalid); dq driven only in the write's issue cycle.
- Idle: no requests for 10 cycles → ce_n, oe_n and we_n all 1, dq high-Z, no gnt/rvalid activity.
